// File: rtl/jk_ff.sv
// Purpose : WIDTH independent clocked JK cells (hold/set/reset/toggle) sharing one clock and one clear.
// Latency : 1 cycle; j/k/clr sampled at a rising edge are visible on q/qbar right after that edge.
// Backpressure: none; every edge is accepted unconditionally.
//
// Ports:
//   clk  - clock; all state updates on the rising edge only
//   clr  - synchronous active-high clear, priority over j/k; loads CLR_VALUE
//   j    - per-cell J (set) inputs
//   k    - per-cell K (reset) inputs
//   q    - registered true outputs
//   qbar - complement outputs, always ~q
module jk_ff #(
   parameter int                 WIDTH     = 1,
   parameter logic [WIDTH-1:0]   CLR_VALUE = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_n;

   // Characteristic equation evaluated bitwise: a cell that is 0 follows j,
   // a cell that is 1 follows ~k. j=k=1 therefore inverts exactly once per
   // edge because the equation reads only the registered state.
   always_comb begin
      w_q_n = (j & ~r_q) | (~k & r_q);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_q <= CLR_VALUE;
      end else begin
         r_q <= w_q_n;
      end
   end

   assign q    = r_q;
   assign qbar = ~r_q;

endmodule

// File: tb/tb_jk_ff.sv
// Purpose : directed self-checking bench for jk_ff (1-bit default and 4-bit with CLR_VALUE=4'b1010).
// Latency : checks sample outputs 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_jk_ff;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // 1-bit instance, default parameters
   logic       clr;
   logic [0:0] j, k, q, qbar;

   // 4-bit instance with a non-zero clear value
   logic       w_clr;
   logic [3:0] w_j, w_k, w_q, w_qbar;

   int n_checks = 0;
   int n_fail   = 0;

   jk_ff u_dut (
      .clk  (clk),
      .clr  (clr),
      .j    (j),
      .k    (k),
      .q    (q),
      .qbar (qbar)
   );

   jk_ff #(.WIDTH(4), .CLR_VALUE(4'b1010)) u_dut_w (
      .clk  (clk),
      .clr  (w_clr),
      .j    (w_j),
      .k    (w_k),
      .q    (w_q),
      .qbar (w_qbar)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      clr = 1'b1; j = 1'b1; k = 1'b1;
      for (int e = 0; e < 2; e++) begin
         tick();
         n_checks++;
         if (q !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_q edge%0d: got %b want 0", e, q);
         end
         n_checks++;
         if (qbar !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_qbar edge%0d: got %b want 1", e, qbar);
         end
      end
   endtask

   task automatic test_set_hold;
      clr = 1'b0; j = 1'b1; k = 1'b0;
      tick();
      n_checks++;
      if (q !== 1'b1 || qbar !== 1'b0) begin
         n_fail++;
         $display("FAIL set: got q=%b qbar=%b want q=1 qbar=0", q, qbar);
      end
      j = 1'b0; k = 1'b0;
      for (int e = 0; e < 5; e++) begin
         tick();
         n_checks++;
         if (q !== 1'b1 || qbar !== 1'b0) begin
            n_fail++;
            $display("FAIL hold edge%0d: got q=%b qbar=%b want q=1 qbar=0", e, q, qbar);
         end
      end
   endtask

   task automatic test_reset_cell;
      j = 1'b0; k = 1'b1;
      for (int e = 0; e < 2; e++) begin
         tick();
         n_checks++;
         if (q !== 1'b0 || qbar !== 1'b1) begin
            n_fail++;
            $display("FAIL kreset edge%0d: got q=%b qbar=%b want q=0 qbar=1", e, q, qbar);
         end
      end
   endtask

   task automatic test_toggle;
      logic exp_q;
      exp_q = 1'b0;
      j = 1'b1; k = 1'b1;
      for (int e = 0; e < 6; e++) begin
         exp_q = ~exp_q;
         tick();
         n_checks++;
         if (q !== exp_q || qbar !== ~exp_q) begin
            n_fail++;
            $display("FAIL toggle edge%0d: got q=%b qbar=%b want q=%b qbar=%b",
                     e, q, qbar, exp_q, ~exp_q);
         end
      end
   endtask

   task automatic test_clr_mid_toggle;
      // q is 0 here; one toggle edge brings it to 1
      j = 1'b1; k = 1'b1;
      tick();
      n_checks++;
      if (q !== 1'b1) begin
         n_fail++;
         $display("FAIL midclr_pre: got %b want 1", q);
      end
      clr = 1'b1;
      tick();
      n_checks++;
      if (q !== 1'b0 || qbar !== 1'b1) begin
         n_fail++;
         $display("FAIL midclr_clear: got q=%b qbar=%b want q=0 qbar=1", q, qbar);
      end
      clr = 1'b0;
      tick();
      n_checks++;
      if (q !== 1'b1 || qbar !== 1'b0) begin
         n_fail++;
         $display("FAIL midclr_resume: got q=%b qbar=%b want q=1 qbar=0", q, qbar);
      end
   endtask

   task automatic test_between_edges;
      // q is 1; pulses on clr and k that fall between edges must be ignored
      j = 1'b0; k = 1'b0;
      #1;
      clr = 1'b1;
      #2;
      n_checks++;
      if (q !== 1'b1) begin
         n_fail++;
         $display("FAIL async_clr: got %b want 1", q);
      end
      clr = 1'b0;
      k = 1'b1;
      #2;
      k = 1'b0;
      tick();
      n_checks++;
      if (q !== 1'b1 || qbar !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_ignore: got q=%b qbar=%b want q=1 qbar=0", q, qbar);
      end
   endtask

   task automatic test_wide;
      logic [3:0] vj   [4];
      logic [3:0] vk   [4];
      logic [3:0] vexp [4];
      w_clr = 1'b1; w_j = 4'b1111; w_k = 4'b1111;
      tick();
      n_checks++;
      if (w_q !== 4'b1010 || w_qbar !== 4'b0101) begin
         n_fail++;
         $display("FAIL wide_clr: got q=%b qbar=%b want q=1010 qbar=0101", w_q, w_qbar);
      end
      w_clr = 1'b0;
      // set/reset mix, full toggle, set+hold mix, reset+hold mix
      vj[0] = 4'b0011; vk[0] = 4'b1100; vexp[0] = 4'b0011;
      vj[1] = 4'b1111; vk[1] = 4'b1111; vexp[1] = 4'b1100;
      vj[2] = 4'b0101; vk[2] = 4'b0000; vexp[2] = 4'b1101;
      vj[3] = 4'b0000; vk[3] = 4'b0110; vexp[3] = 4'b1001;
      for (int v = 0; v < 4; v++) begin
         w_j = vj[v]; w_k = vk[v];
         tick();
         n_checks++;
         if (w_q !== vexp[v] || w_qbar !== ~vexp[v]) begin
            n_fail++;
            $display("FAIL wide_vec%0d: got q=%b qbar=%b want q=%b qbar=%b",
                     v, w_q, w_qbar, vexp[v], ~vexp[v]);
         end
      end
   endtask

   initial begin
      clr   = 1'b1; j = 1'b1; k = 1'b1;
      w_clr = 1'b0; w_j = 4'b0000; w_k = 4'b0000;
      test_reset();
      test_set_hold();
      test_reset_cell();
      test_toggle();
      test_clr_mid_toggle();
      test_between_edges();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
